pe_col_seq_ctrl: RTL and testbench

Sequencer that drives the per-PE control inputs (wire_connection, output_en) of one column of ROWS pe_top instances.
On a start handshake it runs one dot-product job of programmable length K in four phases: LOAD, ACCUMULATE, FORMAT and DRAIN.
It issues a data-request strobe to the upstream bus feeder and a row-indexed valid strobe to the downstream result collector at the column bottom.
It sits directly upstream of the PE column; every PE in the column shares its control outputs.

---
 rtl/pe_col_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_pe_col_seq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_col_seq_ctrl.sv
// Control sequencer for one column of pe_top instances: LOAD / ACC / FORMAT / DRAIN
// per job, with a delayed (valid,row) strobe for the bottom-of-column collector.
module pe_col_seq_ctrl #(
    parameter int ROWS      = 4,
    parameter int WIDTH_K   = 8,
    parameter int DRAIN_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH_K-1:0] k_len_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               data_req_o,
    output logic [1:0]         wire_connection_o,
    output logic               output_en_o,
    output logic               out_valid_o,
    output logic [7:0]         out_row_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACC,
        S_FORMAT,
        S_DRAIN
    } state_t;

    state_t             state_q, state_n;
    logic [WIDTH_K-1:0] cnt_q, cnt_n;
    logic [7:0]         row_q, row_n;

    // Stage 0 is the DRAIN-phase pair itself; stage DRAIN_LAT feeds the collector.
    logic               pv_q [0:DRAIN_LAT];
    logic [7:0]         pr_q [0:DRAIN_LAT];

    logic               abort_eff;
    logic               flush_n;
    logic               busy_n;
    logic               done_n;
    logic               err_n;
    logic               dr_n;
    logic [1:0]         wc_n;
    logic               drain_n;

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        row_n     = row_q;
        err_n     = 1'b0;
        abort_eff = abort_i && busy_o;

        case (state_q)
            S_IDLE: begin
                // busy_o covers the flush of the drain pipe after the FSM is back in IDLE.
                if (start_i && !busy_o) begin
                    if (k_len_i != '0) begin
                        state_n = S_LOAD;
                        cnt_n   = k_len_i;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_LOAD, S_ACC: begin
                if (cnt_q <= WIDTH_K'(1)) begin
                    state_n = S_FORMAT;
                    cnt_n   = '0;
                end else begin
                    state_n = S_ACC;
                    cnt_n   = cnt_q - WIDTH_K'(1);
                end
            end
            S_FORMAT: begin
                state_n = S_DRAIN;
                row_n   = 8'(ROWS - 1);
            end
            S_DRAIN: begin
                if (row_q == '0) begin
                    state_n = S_IDLE;
                end else begin
                    row_n = row_q - 8'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (abort_eff) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            row_n   = '0;
        end

        flush_n = 1'b0;
        for (int unsigned i = 0; i < DRAIN_LAT; i++) begin
            flush_n = flush_n | pv_q[i];
        end

        busy_n  = !abort_eff && ((state_n != S_IDLE) || flush_n);
        done_n  = busy_o && !busy_n && !abort_eff;
        drain_n = (state_n == S_DRAIN);

        wc_n = 2'd3;
        dr_n = 1'b0;
        case (state_n)
            S_LOAD:  begin wc_n = 2'd0; dr_n = 1'b1; end
            S_ACC:   begin wc_n = 2'd1; dr_n = 1'b1; end
            S_DRAIN: wc_n = 2'd2;
            default: wc_n = 2'd3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            row_q             <= '0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            err_o             <= 1'b0;
            data_req_o        <= 1'b0;
            wire_connection_o <= 2'd3;
            for (int unsigned i = 0; i <= DRAIN_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pr_q[i] <= '0;
            end
        end else begin
            state_q           <= state_n;
            cnt_q             <= cnt_n;
            row_q             <= row_n;
            busy_o            <= busy_n;
            done_o            <= done_n;
            err_o             <= err_n;
            data_req_o        <= dr_n;
            wire_connection_o <= wc_n;
            pv_q[0]           <= drain_n;
            pr_q[0]           <= drain_n ? row_n : '0;
            for (int unsigned i = 1; i <= DRAIN_LAT; i++) begin
                pv_q[i] <= abort_eff ? 1'b0 : pv_q[i-1];
                pr_q[i] <= abort_eff ? '0   : pr_q[i-1];
            end
        end
    end

    assign output_en_o = pv_q[0];
    assign out_valid_o = pv_q[DRAIN_LAT];
    assign out_row_o   = pr_q[DRAIN_LAT];

endmodule

// File: tb/tb_pe_col_seq_ctrl.sv
// Directed bench for pe_col_seq_ctrl: job sequencing, K edge cases, ignored starts,
// abort and asynchronous reset mid-job.
module tb_pe_col_seq_ctrl;

    localparam int ROWS    = 4;
    localparam int WIDTH_K = 8;
    localparam int LAT     = 2;

    logic               clk;
    logic               rst_n;
    logic               start_i;
    logic [WIDTH_K-1:0] k_len_i;
    logic               abort_i;
    logic               busy_o;
    logic               done_o;
    logic               err_o;
    logic               data_req_o;
    logic [1:0]         wire_connection_o;
    logic               output_en_o;
    logic               out_valid_o;
    logic [7:0]         out_row_o;

    int n_assert;
    int n_fail;

    pe_col_seq_ctrl #(
        .ROWS      (ROWS),
        .WIDTH_K   (WIDTH_K),
        .DRAIN_LAT (LAT)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_i           (start_i),
        .k_len_i           (k_len_i),
        .abort_i           (abort_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .data_req_o        (data_req_o),
        .wire_connection_o (wire_connection_o),
        .output_en_o       (output_en_o),
        .out_valid_o       (out_valid_o),
        .out_row_o         (out_row_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " wc"},   32'(wire_connection_o), 32'd3);
        chk({tag, " oe"},   32'(output_en_o),       32'd0);
        chk({tag, " dreq"}, 32'(data_req_o),        32'd0);
        chk({tag, " busy"}, 32'(busy_o),            32'd0);
        chk({tag, " ov"},   32'(out_valid_o),       32'd0);
        chk({tag, " row"},  32'(out_row_o),         32'd0);
        chk({tag, " done"}, 32'(done_o),            32'd0);
        chk({tag, " err"},  32'(err_o),             32'd0);
    endtask

    // Runs one job of length k from IDLE, checking every output cycle by cycle.
    // start_i is re-pulsed in cycles p1/p2 to show it is ignored while busy.
    // Returns at the negedge one cycle after done_o.
    task automatic run_job(input int k, input int p1, input int p2);
        int exp_wc, exp_dr, exp_oe, exp_busy, exp_ov, exp_row, exp_done;
        int last;
        start_i = 1'b1;
        k_len_i = WIDTH_K'(k);
        @(negedge clk);
        start_i = 1'b0;
        k_len_i = 8'd3;
        last = k + ROWS + LAT + 2;
        for (int c = 0; c <= last; c++) begin
            if (c == 0)                          exp_wc = 0;
            else if (c <= k - 1)                 exp_wc = 1;
            else if (c == k)                     exp_wc = 3;
            else if (c <= k + ROWS)              exp_wc = 2;
            else                                 exp_wc = 3;
            exp_dr   = (c <= k - 1) ? 1 : 0;
            exp_oe   = (c >= k + 1 && c <= k + ROWS) ? 1 : 0;
            exp_ov   = (c >= k + 1 + LAT && c <= k + ROWS + LAT) ? 1 : 0;
            exp_row  = exp_ov ? (ROWS - 1 - (c - (k + 1 + LAT))) : 0;
            exp_busy = (c <= k + ROWS + LAT) ? 1 : 0;
            exp_done = (c == k + ROWS + LAT + 1) ? 1 : 0;
            chk($sformatf("k%0d c%0d wc", k, c),   32'(wire_connection_o), 32'(exp_wc));
            chk($sformatf("k%0d c%0d dreq", k, c), 32'(data_req_o),        32'(exp_dr));
            chk($sformatf("k%0d c%0d oe", k, c),   32'(output_en_o),       32'(exp_oe));
            chk($sformatf("k%0d c%0d ov", k, c),   32'(out_valid_o),       32'(exp_ov));
            chk($sformatf("k%0d c%0d row", k, c),  32'(out_row_o),         32'(exp_row));
            chk($sformatf("k%0d c%0d busy", k, c), 32'(busy_o),            32'(exp_busy));
            chk($sformatf("k%0d c%0d done", k, c), 32'(done_o),            32'(exp_done));
            chk($sformatf("k%0d c%0d err", k, c),  32'(err_o),             32'd0);
            if (c == last) break;
            start_i = (c == p1 || c == p2) ? 1'b1 : 1'b0;
            @(negedge clk);
            start_i = 1'b0;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start_i  = 1'b0;
        k_len_i  = '0;
        abort_i  = 1'b0;

        // Reset state
        @(negedge clk);
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post-reset");

        // K=5 nominal job, then K=1 straight from LOAD to FORMAT
        run_job(5, -1, -1);
        run_job(1, -1, -1);

        // K=0 rejected with a single err_o pulse
        start_i = 1'b1;
        k_len_i = 8'd0;
        @(negedge clk);
        start_i = 1'b0;
        chk("k0 err",  32'(err_o),             32'd1);
        chk("k0 busy", 32'(busy_o),            32'd0);
        chk("k0 wc",   32'(wire_connection_o), 32'd3);
        chk("k0 dreq", 32'(data_req_o),        32'd0);
        @(negedge clk);
        chk_idle("k0 after");

        // K=10 with starts during ACC (c3) and during flush (c15), then an
        // immediate back-to-back K=2 job one cycle after done_o
        run_job(10, 3, 10 + ROWS + 1);
        run_job(2, -1, -1);

        // abort_i and start_i together in IDLE: start wins
        abort_i = 1'b1;
        start_i = 1'b1;
        k_len_i = 8'd2;
        @(negedge clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("abort+start wc",   32'(wire_connection_o), 32'd0);
        chk("abort+start busy", 32'(busy_o),            32'd1);
        for (int c = 0; c < 12; c++) @(negedge clk);
        chk_idle("abort+start end");

        // K=8 aborted on the 3rd ACC cycle
        start_i = 1'b1;
        k_len_i = 8'd8;
        @(negedge clk);
        start_i = 1'b0;
        chk("abort c0 wc", 32'(wire_connection_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort c3 wc",   32'(wire_connection_o), 32'd1);
        chk("abort c3 dreq", 32'(data_req_o),        32'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk_idle("abort next");
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk($sformatf("abort quiet c%0d ov", c),   32'(out_valid_o), 32'd0);
            chk($sformatf("abort quiet c%0d done", c), 32'(done_o),      32'd0);
        end

        // Asynchronous reset in the middle of DRAIN (K=3: DRAIN c4..c7, out_valid from c6)
        start_i = 1'b1;
        k_len_i = 8'd3;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 6; c++) @(negedge clk);
        chk("rst mid oe", 32'(output_en_o), 32'd1);
        chk("rst mid ov", 32'(out_valid_o), 32'd1);
        chk("rst mid row", 32'(out_row_o),  32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst c%0d done", c), 32'(done_o), 32'd0);
            chk($sformatf("post-rst c%0d busy", c), 32'(busy_o), 32'd0);
        end
        run_job(2, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
